// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB requester and its wait-state timer.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 8;
    localparam int unsigned APB_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state counter for the ACCESS phase; flags expiry once TIMEOUT-1 stalled cycles have passed.
module apb_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_count;

    // Saturates at the expiry value so the count never wraps.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && !o_expired) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_expired = (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/apb_master.sv
// APB requester: one valid/ready command becomes one SETUP+ACCESS transfer with a held response.
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = APB_ADDR_W,
    parameter int unsigned DATA_WIDTH = APB_DATA_W,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic                  cmd_strb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic                  PSTRB,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    apb_mst_state_t r_state, w_state_nxt;

    logic                  r_psel, r_penable, r_pwrite, r_pstrb;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic                  r_rsp_valid, r_rsp_err, r_rsp_timeout;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;

    logic                  w_psel, w_penable, w_pwrite, w_pstrb;
    logic [ADDR_WIDTH-1:0] w_paddr;
    logic [DATA_WIDTH-1:0] w_pwdata;
    logic                  w_rsp_valid, w_rsp_err, w_rsp_timeout;
    logic [DATA_WIDTH-1:0] w_rsp_rdata;

    logic w_expired;
    logic w_tmr_clr;
    logic w_tmr_en;

    assign w_tmr_clr = (r_state == SETUP);
    assign w_tmr_en  = (r_state == ACCESS) && !PREADY;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .i_clk     (PCLK),
        .i_rst     (PRESET),
        .i_clr     (w_tmr_clr),
        .i_en      (w_tmr_en),
        .o_expired (w_expired)
    );

    // State and all APB/response outputs update together on the clock edge.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state       <= IDLE;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_pstrb       <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_rsp_rdata   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_psel        <= w_psel;
            r_penable     <= w_penable;
            r_pwrite      <= w_pwrite;
            r_pstrb       <= w_pstrb;
            r_paddr       <= w_paddr;
            r_pwdata      <= w_pwdata;
            r_rsp_valid   <= w_rsp_valid;
            r_rsp_err     <= w_rsp_err;
            r_rsp_timeout <= w_rsp_timeout;
            r_rsp_rdata   <= w_rsp_rdata;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (cmd_valid) w_state_nxt = SETUP;
            SETUP:   w_state_nxt = ACCESS;
            ACCESS:  if (PREADY || w_expired) w_state_nxt = RESP;
            RESP:    if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs; everything holds unless a transition touches it.
    always_comb begin
        w_psel        = r_psel;
        w_penable     = r_penable;
        w_pwrite      = r_pwrite;
        w_pstrb       = r_pstrb;
        w_paddr       = r_paddr;
        w_pwdata      = r_pwdata;
        w_rsp_valid   = r_rsp_valid;
        w_rsp_err     = r_rsp_err;
        w_rsp_timeout = r_rsp_timeout;
        w_rsp_rdata   = r_rsp_rdata;
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_paddr   = cmd_addr;
                    w_pwdata  = cmd_wdata;
                    w_pwrite  = cmd_write;
                    w_pstrb   = cmd_strb & cmd_write;
                    w_psel    = 1'b1;
                    w_penable = 1'b0;
                end
            end
            SETUP: begin
                w_penable = 1'b1;
            end
            ACCESS: begin
                if (PREADY) begin
                    w_rsp_rdata   = r_pwrite ? '0 : PRDATA;
                    w_rsp_err     = PSLVERR;
                    w_rsp_timeout = 1'b0;
                    w_rsp_valid   = 1'b1;
                    w_psel        = 1'b0;
                    w_penable     = 1'b0;
                end else if (w_expired) begin
                    w_rsp_rdata   = '0;
                    w_rsp_err     = 1'b1;
                    w_rsp_timeout = 1'b1;
                    w_rsp_valid   = 1'b1;
                    w_psel        = 1'b0;
                    w_penable     = 1'b0;
                end
            end
            RESP: begin
                if (rsp_ready) w_rsp_valid = 1'b0;
            end
            default: ;
        endcase
    end

    assign cmd_ready   = (r_state == IDLE);
    assign PSEL        = r_psel;
    assign PENABLE     = r_penable;
    assign PWRITE      = r_pwrite;
    assign PSTRB       = r_pstrb;
    assign PADDR       = r_paddr;
    assign PWDATA      = r_pwdata;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;
    assign rsp_rdata   = r_rsp_rdata;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master against a small 8x8 memory completer with programmable wait states.
module tb_apb_master;
    import apb_pkg::*;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;
    localparam int unsigned TO = 16;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          cmd_valid, cmd_ready, cmd_write, cmd_strb;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic          PSEL, PENABLE, PWRITE, PSTRB;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA;
    logic          PREADY, PSLVERR;

    int n_checks = 0;
    int n_fail   = 0;

    // Completer model
    logic [DW-1:0] mem [8];
    int            acc_cnt;
    int            wait_n;
    logic          stuck;

    always #5 PCLK = ~PCLK;

    apb_master #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PSTRB       (PSTRB),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    assign PREADY  = PSEL && PENABLE && !stuck && (acc_cnt == wait_n);
    assign PSLVERR = PREADY && (PADDR >= AW'(8));
    assign PRDATA  = (PADDR < AW'(8)) ? mem[PADDR[2:0]] : '0;

    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) acc_cnt <= 0;
        else if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    always @(posedge PCLK) begin
        if (!PRESET && PSEL && PENABLE && PREADY && PWRITE && PADDR < AW'(8))
            mem[PADDR[2:0]] <= PWDATA;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Present a command in IDLE; returns at the negedge of the SETUP cycle.
    task automatic start_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        check("cmd_ready idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_strb  = 1'b1;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        check("setup psel", 32'(PSEL), 32'd1);
        check("setup penable", 32'(PENABLE), 32'd0);
    endtask

    // Walk the ACCESS phase checking stable APB outputs, then check the response.
    task automatic wait_rsp(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input int exp_acc, input apb_rsp_t exp);
        int n = 0;
        @(negedge PCLK);
        while (PSEL && PENABLE && n < 40) begin
            check("access paddr", 32'(PADDR), 32'(a));
            check("access pwrite", 32'(PWRITE), 32'(w));
            check("access pstrb", 32'(PSTRB), 32'(w));
            if (w) check("access pwdata", 32'(PWDATA), 32'(d));
            check("access rsp_valid low", 32'(rsp_valid), 32'd0);
            n++;
            @(negedge PCLK);
        end
        check("access cycles", 32'(n), 32'(exp_acc));
        check("resp psel", 32'(PSEL), 32'd0);
        check("resp penable", 32'(PENABLE), 32'd0);
        check("resp valid", 32'(rsp_valid), 32'd1);
        check("resp cmd_ready", 32'(cmd_ready), 32'd0);
        check("resp rdata", 32'(rsp_rdata), 32'(exp.rdata));
        check("resp err", 32'(rsp_err), 32'(exp.err));
        check("resp timeout", 32'(rsp_timeout), 32'(exp.timeout));
        check("paddr kept", 32'(PADDR), 32'(a));
    endtask

    task automatic ack_rsp();
        rsp_ready = 1'b1;
        @(negedge PCLK);
        rsp_ready = 1'b0;
        check("ack rsp_valid", 32'(rsp_valid), 32'd0);
        check("ack cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = '0;
        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_strb  = 1'b0;
        rsp_ready = 1'b0;
        wait_n    = 0;
        stuck     = 1'b0;
        repeat (2) @(negedge PCLK);

        check("rst psel", 32'(PSEL), 32'd0);
        check("rst penable", 32'(PENABLE), 32'd0);
        check("rst paddr", 32'(PADDR), 32'd0);
        check("rst pwdata", 32'(PWDATA), 32'd0);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst cmd_ready", 32'(cmd_ready), 32'd1);
        PRESET = 1'b0;
        @(negedge PCLK);

        // Immediate write
        wait_n = 0;
        start_cmd(1'b1, 8'h03, 8'hA5);
        wait_rsp(1'b1, 8'h03, 8'hA5, 1, '{rdata: 8'h00, err: 1'b0, timeout: 1'b0});
        ack_rsp();

        // Write then read back with PREADY in the 5th ACCESS cycle
        wait_n = 4;
        start_cmd(1'b1, 8'h02, 8'h5C);
        wait_rsp(1'b1, 8'h02, 8'h5C, 5, '{rdata: 8'h00, err: 1'b0, timeout: 1'b0});
        ack_rsp();
        start_cmd(1'b0, 8'h02, 8'hFF);
        wait_rsp(1'b0, 8'h02, 8'hFF, 5, '{rdata: 8'h5C, err: 1'b0, timeout: 1'b0});
        ack_rsp();

        // Out-of-range write returns PSLVERR
        start_cmd(1'b1, 8'h10, 8'h77);
        wait_rsp(1'b1, 8'h10, 8'h77, 5, '{rdata: 8'h00, err: 1'b1, timeout: 1'b0});
        ack_rsp();

        // Completer never ready: abort after TIMEOUT cycles, read data forced to 0
        stuck = 1'b1;
        start_cmd(1'b0, 8'h03, 8'h00);
        wait_rsp(1'b0, 8'h03, 8'h00, 16, '{rdata: 8'h00, err: 1'b1, timeout: 1'b1});
        ack_rsp();
        stuck = 1'b0;

        // Response backpressure with a second command pending
        wait_n = 0;
        start_cmd(1'b0, 8'h02, 8'h00);
        wait_rsp(1'b0, 8'h02, 8'h00, 1, '{rdata: 8'h5C, err: 1'b0, timeout: 1'b0});
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h03;
        for (int i = 0; i < 6; i++) begin
            check("bp rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp rsp_rdata", 32'(rsp_rdata), 32'h5C);
            check("bp cmd_ready", 32'(cmd_ready), 32'd0);
            check("bp psel", 32'(PSEL), 32'd0);
            @(negedge PCLK);
        end
        rsp_ready = 1'b1;
        @(negedge PCLK);
        rsp_ready = 1'b0;
        check("bp release rsp_valid", 32'(rsp_valid), 32'd0);
        check("bp release cmd_ready", 32'(cmd_ready), 32'd1);
        check("bp release psel", 32'(PSEL), 32'd0);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        check("bp second psel", 32'(PSEL), 32'd1);
        check("bp second penable", 32'(PENABLE), 32'd0);
        wait_rsp(1'b0, 8'h03, 8'h00, 1, '{rdata: 8'hA5, err: 1'b0, timeout: 1'b0});
        ack_rsp();

        // Reset asserted between edges during ACCESS
        stuck = 1'b1;
        start_cmd(1'b0, 8'h03, 8'h00);
        repeat (3) @(negedge PCLK);
        check("pre-reset penable", 32'(PENABLE), 32'd1);
        #2 PRESET = 1'b1;
        #1;
        check("async rst psel", 32'(PSEL), 32'd0);
        check("async rst penable", 32'(PENABLE), 32'd0);
        check("async rst rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge PCLK);
        PRESET = 1'b0;
        stuck  = 1'b0;
        #1;
        check("post-rst cmd_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            check("post-rst rsp_valid", 32'(rsp_valid), 32'd0);
            check("post-rst psel", 32'(PSEL), 32'd0);
        end

        // Normal operation resumes after reset
        wait_n = 4;
        start_cmd(1'b0, 8'h02, 8'h00);
        wait_rsp(1'b0, 8'h02, 8'h00, 5, '{rdata: 8'h5C, err: 1'b0, timeout: 1'b0});
        ack_rsp();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester that turns a simple valid/ready command interface into single APB transfers (SETUP then ACCESS) toward one APB completer, such as the team's 8x8 memory slave.
- Handles completer wait states by holding ACCESS until PREADY.
- Returns read data and error status on a held response interface.
- A wait-state timeout guards against a completer that never asserts PREADY.

Parameters:
- ADDR_WIDTH, 8, width of PADDR and cmd_addr.
- DATA_WIDTH, 8, width of PWDATA, PRDATA, cmd_wdata and rsp_rdata.
- TIMEOUT, 16, maximum ACCESS cycles with PREADY=0 before abort. Must be >= 1.

Ports:
- PCLK  in  1  clock; everything is sampled on the rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  master can accept a command (high only in IDLE).
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  transfer address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_strb  in  1  write strobe, forwarded to PSTRB on writes.
- rsp_valid  out  1  response available; held until rsp_ready.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_err  out  1  PSLVERR was seen at completion, or a timeout occurred.
- rsp_timeout  out  1  transfer was aborted by timeout.
- PSEL, PENABLE, PWRITE, PSTRB  out  1 each  APB control.
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY, PSLVERR  in  1 each  APB completion and error.

Behaviour:
- Reset, asynchronous on PRESET=1:
  - state=IDLE.
  - PSEL, PENABLE, PWRITE and PSTRB = 0; PADDR and PWDATA = 0.
  - rsp_valid, rsp_err and rsp_timeout = 0; rsp_rdata = 0; wait counter = 0.
  - Any in-flight transfer is dropped with no response. PSEL falls immediately, without waiting for an edge.
- FSM states: IDLE, SETUP, ACCESS, RESP. All APB outputs are registered.
- IDLE:
  - cmd_ready=1 (combinational decode of the state).
  - On cmd_valid & cmd_ready, the next edge loads PADDR, PWDATA, PWRITE and PSTRB (= cmd_strb & cmd_write), sets PSEL=1 and PENABLE=0, and moves to SETUP.
- SETUP: lasts exactly one cycle. The next edge sets PENABLE=1, clears the wait counter and moves to ACCESS.
- ACCESS: sample PREADY at every edge.
  - PREADY=1:
    - Capture rsp_rdata = PRDATA on reads, 0 on writes.
    - rsp_err = PSLVERR; rsp_timeout = 0.
    - Drop PSEL and PENABLE, set rsp_valid=1 and go to RESP.
  - PREADY=0 and counter == TIMEOUT-1:
    - Abort: drop PSEL and PENABLE.
    - rsp_err=1, rsp_timeout=1, rsp_rdata=0, rsp_valid=1; go to RESP.
  - Otherwise: increment the counter and hold every APB output.
- PSLVERR is ignored unless PREADY=1 in the same cycle.
- PADDR, PWRITE, PWDATA and PSTRB stay constant from SETUP through the last ACCESS cycle. They keep their value after the transfer; they are not cleared.
- RESP:
  - rsp_valid=1; rsp_rdata, rsp_err and rsp_timeout are stable.
  - On rsp_ready=1 the next edge clears rsp_valid and moves to IDLE.
  - cmd_ready=0 throughout RESP. This gives at least one idle APB cycle between transfers, with no back-to-back SETUP.
- Latency:
  - Best case (PREADY already high in the first ACCESS cycle): accept edge k, SETUP in cycle k+1, ACCESS in cycle k+2, rsp_valid from edge k+3.
  - Each wait state adds one cycle.
- Wait counter width is $clog2(TIMEOUT+1); it never wraps.
- cmd_* inputs are ignored outside IDLE. rsp_ready is ignored outside RESP.

Decomposition:
- Package apb_pkg holds:
  - the state enum apb_mst_state_t (IDLE, SETUP, ACCESS, RESP);
  - localparam defaults for ADDR_WIDTH and DATA_WIDTH;
  - a response struct {rdata, err, timeout}.
- One sub-module, apb_wait_timer: a clear/enable counter with an expired flag at TIMEOUT-1, instantiated once.

Test Plan:
- Write with immediate completion: addr 0x03, data 0xA5, PREADY tied 1. Expect SETUP for 1 cycle (PSEL=1, PENABLE=0), ACCESS for 1 cycle, then rsp_valid with rsp_err=0 and rsp_rdata=0.
- Read-back through the memory slave, whose PREADY arrives in the 5th ACCESS cycle:
  - Write 0x5C to 0x02, then read 0x02.
  - Expect rsp_rdata=0x5C, 5 ACCESS cycles, and APB signals stable throughout.
- Error response: write to 0x10 on the memory slave. Expect rsp_err=1, rsp_timeout=0, and PSEL low on the cycle after PREADY.
- Timeout: PREADY held 0, TIMEOUT=16. Expect exactly 16 ACCESS cycles, then PSEL=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- Response backpressure: hold rsp_ready=0 for 6 cycles with a second cmd_valid pending.
  - Expect rsp_valid and rsp_rdata held, cmd_ready=0 and no new PSEL.
  - After rsp_ready=1, the second command is accepted in IDLE.
- Reset mid-ACCESS: assert PRESET between clock edges. Expect PSEL, PENABLE and rsp_valid to drop at once, with no response after PRESET releases and cmd_ready=1 on the first cycle after release.
